// File: rtl/dpc_multiline_buf.sv
// Multi-line delay buffer for dead-pixel correction: presents the current pixel
// plus the same column from the previous NUM_LINES lines on every valid cycle.
module dpc_multiline_buf #(
  parameter int DATA_W    = 16,
  parameter int NUM_LINES = 4,
  parameter int MAX_LINE  = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sof,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               data_in,
  input  logic [ADDR_W:0]                 line_len,
  output logic                            out_valid,
  output logic [(NUM_LINES+1)*DATA_W-1:0] taps,
  output logic [NUM_LINES:0]              tap_vld,
  output logic [ADDR_W-1:0]               col,
  output logic                            cfg_err
);

  localparam int LC_W = $clog2(NUM_LINES + 1);
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(MAX_LINE);
  localparam logic [ADDR_W:0] MIN_LEN = (ADDR_W+1)'(2);
  localparam logic [LC_W-1:0] LC_MAX  = LC_W'(NUM_LINES);

  // Returns {illegal, clamped_len}.
  function automatic logic [ADDR_W+1:0] clamp_len(input logic [ADDR_W:0] len);
    logic [ADDR_W+1:0] r;
    if (len < MIN_LEN) begin
      r = {1'b1, MIN_LEN};
    end else if (len > MAX_LEN) begin
      r = {1'b1, MAX_LEN};
    end else begin
      r = {1'b0, len};
    end
    return r;
  endfunction

  logic [ADDR_W-1:0]           ptr_r;
  logic [LC_W-1:0]             line_cnt_r;
  logic [ADDR_W:0]             len_q_r;
  logic                        cfg_err_r;
  logic                        s1_valid_r;
  logic [DATA_W-1:0]           data_d_r;
  logic [ADDR_W-1:0]           ptr_d_r;
  logic [LC_W-1:0]             line_cnt_d_r;

  logic [ADDR_W+1:0]           clamp_s;
  logic [ADDR_W-1:0]           ptr_eff_s;
  logic [LC_W-1:0]             cnt_eff_s;
  logic [ADDR_W:0]             len_eff_s;
  logic                        wrap_s;
  logic [ADDR_W-1:0]           ptr_nxt_s;
  logic [LC_W-1:0]             cnt_nxt_s;
  logic [NUM_LINES*DATA_W-1:0] rd_s;
  logic [NUM_LINES:0]          tap_vld_s;
  logic [(NUM_LINES+1)*DATA_W-1:0] taps_s;

  // Stage-0 pointer/line bookkeeping; sof restarts the frame before the pixel is used.
  always_comb begin
    clamp_s = clamp_len(line_len);
    if (sof) begin
      ptr_eff_s = {ADDR_W{1'b0}};
      cnt_eff_s = {LC_W{1'b0}};
      len_eff_s = clamp_s[ADDR_W:0];
    end else begin
      ptr_eff_s = ptr_r;
      cnt_eff_s = line_cnt_r;
      len_eff_s = len_q_r;
    end
    wrap_s = ({1'b0, ptr_eff_s} == (len_eff_s - (ADDR_W+1)'(1)));
    if (wrap_s) begin
      ptr_nxt_s = {ADDR_W{1'b0}};
      cnt_nxt_s = (cnt_eff_s == LC_MAX) ? LC_MAX : (cnt_eff_s + LC_W'(1));
    end else begin
      ptr_nxt_s = ptr_eff_s + ADDR_W'(1);
      cnt_nxt_s = cnt_eff_s;
    end
  end

  // Frame state and stage-1 pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r        <= {ADDR_W{1'b0}};
      line_cnt_r   <= {LC_W{1'b0}};
      len_q_r      <= MAX_LEN;
      cfg_err_r    <= 1'b0;
      s1_valid_r   <= 1'b0;
      data_d_r     <= {DATA_W{1'b0}};
      ptr_d_r      <= {ADDR_W{1'b0}};
      line_cnt_d_r <= {LC_W{1'b0}};
    end else begin
      len_q_r    <= len_eff_s;
      s1_valid_r <= in_valid;
      if (sof) begin
        cfg_err_r <= clamp_s[ADDR_W+1];
      end
      if (in_valid) begin
        ptr_r        <= ptr_nxt_s;
        line_cnt_r   <= cnt_nxt_s;
        data_d_r     <= data_in;
        ptr_d_r      <= ptr_eff_s;
        line_cnt_d_r <= cnt_eff_s;
      end else begin
        ptr_r      <= ptr_eff_s;
        line_cnt_r <= cnt_eff_s;
      end
    end
  end

  // One line RAM per delayed line; each feeds the next so RAM j holds data j+1 lines old.
  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    logic [DATA_W-1:0] mem_r [MAX_LINE];
    logic [DATA_W-1:0] rd_r;
    logic [DATA_W-1:0] wr_data_s;

    if (g == 0) begin : g_head
      assign wr_data_s = data_d_r;
    end else begin : g_casc
      assign wr_data_s = rd_s[(g-1)*DATA_W +: DATA_W];
    end

    // Read at the stage-0 pointer, write back at the stage-1 pointer (never equal mid-line).
    always_ff @(posedge clk) begin
      if (in_valid) begin
        rd_r <= mem_r[ptr_eff_s];
      end
      if (s1_valid_r) begin
        mem_r[ptr_d_r] <= wr_data_s;
      end
    end

    assign rd_s[g*DATA_W +: DATA_W] = rd_r;
  end

  // Qualify taps by how many lines of this frame are buffered; unqualified taps read as zero.
  always_comb begin
    tap_vld_s    = {(NUM_LINES+1){1'b0}};
    tap_vld_s[0] = s1_valid_r;
    for (int j = 1; j <= NUM_LINES; j++) begin
      tap_vld_s[j] = s1_valid_r && (line_cnt_d_r >= LC_W'(j));
    end
    taps_s = {((NUM_LINES+1)*DATA_W){1'b0}};
    taps_s[DATA_W-1:0] = data_d_r & {DATA_W{tap_vld_s[0]}};
    for (int j = 1; j <= NUM_LINES; j++) begin
      taps_s[j*DATA_W +: DATA_W] = rd_s[(j-1)*DATA_W +: DATA_W] & {DATA_W{tap_vld_s[j]}};
    end
  end

  assign out_valid = s1_valid_r;
  assign col       = ptr_d_r;
  assign cfg_err   = cfg_err_r;
  assign tap_vld   = tap_vld_s;
  assign taps      = taps_s;

endmodule

// File: tb/tb_dpc_multiline_buf.sv
// Directed bench for dpc_multiline_buf: hand-computed vector table, corner
// sequences, and a pixel-history scoreboard checked on every cycle.
module tb_dpc_multiline_buf;

  localparam int DW = 16;
  localparam int NL = 4;
  localparam int ML = 1024;
  localparam int AW = 10;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sof;
  logic                 in_valid;
  logic [DW-1:0]        data_in;
  logic [AW:0]          line_len;
  logic                 out_valid;
  logic [(NL+1)*DW-1:0] taps;
  logic [NL:0]          tap_vld;
  logic [AW-1:0]        col;
  logic                 cfg_err;

  always #5 clk = ~clk;

  dpc_multiline_buf #(.DATA_W(DW), .NUM_LINES(NL), .MAX_LINE(ML), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .sof(sof), .in_valid(in_valid), .data_in(data_in),
    .line_len(line_len), .out_valid(out_valid), .taps(taps), .tap_vld(tap_vld),
    .col(col), .cfg_err(cfg_err)
  );

  typedef struct {
    logic        sof;
    logic        vld;
    logic [15:0] din;
    int          len;
    logic        e_ov;
    int          e_col;
    logic [4:0]  e_tv;
    logic        e_err;
    logic [15:0] e_tap0;
  } vec_t;

  localparam int NT = 22;
  vec_t tbl [NT];

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: every valid pixel of the current frame, indexed by arrival order.
  logic [DW-1:0] hist [0:8191];
  int   m_n, m_line, m_col, m_len;
  logic m_err;

  function automatic int clamp_len(input int len);
    if (len < 2) return 2;
    else if (len > ML) return ML;
    else return len;
  endfunction

  function automatic logic len_bad(input int len);
    return (len < 2) || (len > ML);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      if (err_cnt <= 100) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive, advance the model, compare after the edge.
  task automatic cyc(input logic s, input logic v, input logic [15:0] d, input int len);
    logic                 e_ov;
    logic [(NL+1)*DW-1:0] e_taps;
    logic [NL:0]          e_tv;
    int                   e_col;
    sof = s; in_valid = v; data_in = d; line_len = 11'(len);
    if (s) begin
      m_len = clamp_len(len); m_err = len_bad(len);
      m_n = 0; m_line = 0; m_col = 0;
    end
    e_ov = v; e_taps = '0; e_tv = '0; e_col = m_col;
    if (v) begin
      hist[m_n] = d;
      for (int j = 0; j <= NL; j++) begin
        if (m_line >= j) begin
          e_tv[j] = 1'b1;
          e_taps[j*DW +: DW] = hist[m_n - j*m_len];
        end
      end
      m_n++; m_col++;
      if (m_col == m_len) begin
        m_col = 0; m_line++;
      end
    end
    @(posedge clk); #1;
    chk("out_valid", out_valid, e_ov);
    chk("tap_vld", tap_vld, e_tv);
    chk("taps", taps, e_taps);
    if (v) chk("col", col, e_col);
    chk("cfg_err", cfg_err, m_err);
    sof = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_reset(input logic v);
    reset = 1'b1; sof = 1'b0; in_valid = v; data_in = 16'hdead;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    m_len = ML; m_err = 1'b0; m_n = 0; m_line = 0; m_col = 0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_taps", taps, 80'h0);
    chk("rst_tap_vld", tap_vld, 5'b00000);
    chk("rst_col", col, 10'd0);
    chk("rst_cfg_err", cfg_err, 1'b0);
  endtask

  // 5-line ramp frame of 8-pixel lines, value = line*16+col, optionally with idle gaps.
  task automatic run_ramp(input logic gappy);
    for (int p = 0; p < 40; p++) begin
      int ln, c, gaps;
      ln = p / 8; c = p % 8;
      gaps = gappy ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < gaps; k++) cyc(1'b0, 1'b0, 16'h0, 0);
      cyc(p == 0, 1'b1, 16'(ln*16 + c), 8);
      if (ln == 4 && c == 3) begin
        chk("l4c3_taps", taps, 80'h0003_0013_0023_0033_0043);
        chk("l4c3_tv", tap_vld, 5'b11111);
      end
      if (ln == 1 && c == 0) begin
        chk("l1c0_tv", tap_vld, 5'b00011);
        chk("l1c0_hi", taps[79:32], 48'h0);
      end
    end
  endtask

  initial begin
    // Mid-line sof (line_len 6), illegal line_len=1, then sof-only with line_len=4.
    tbl[0]  = '{1'b1, 1'b1, 16'h0100, 6, 1'b1, 0, 5'b00001, 1'b0, 16'h0100};
    tbl[1]  = '{1'b0, 1'b1, 16'h0101, 0, 1'b1, 1, 5'b00001, 1'b0, 16'h0101};
    tbl[2]  = '{1'b0, 1'b1, 16'h0102, 0, 1'b1, 2, 5'b00001, 1'b0, 16'h0102};
    tbl[3]  = '{1'b0, 1'b1, 16'h0103, 0, 1'b1, 3, 5'b00001, 1'b0, 16'h0103};
    tbl[4]  = '{1'b0, 1'b1, 16'h0104, 0, 1'b1, 4, 5'b00001, 1'b0, 16'h0104};
    tbl[5]  = '{1'b0, 1'b1, 16'h0105, 0, 1'b1, 5, 5'b00001, 1'b0, 16'h0105};
    tbl[6]  = '{1'b0, 1'b1, 16'h0110, 0, 1'b1, 0, 5'b00011, 1'b0, 16'h0110};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 0, 1'b0, 0, 5'b00000, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 1'b1, 16'h0111, 0, 1'b1, 1, 5'b00011, 1'b0, 16'h0111};
    tbl[9]  = '{1'b1, 1'b1, 16'h0200, 1, 1'b1, 0, 5'b00001, 1'b1, 16'h0200};
    tbl[10] = '{1'b0, 1'b1, 16'h0201, 0, 1'b1, 1, 5'b00001, 1'b1, 16'h0201};
    tbl[11] = '{1'b0, 1'b1, 16'h0210, 0, 1'b1, 0, 5'b00011, 1'b1, 16'h0210};
    tbl[12] = '{1'b0, 1'b1, 16'h0211, 0, 1'b1, 1, 5'b00011, 1'b1, 16'h0211};
    tbl[13] = '{1'b0, 1'b1, 16'h0220, 0, 1'b1, 0, 5'b00111, 1'b1, 16'h0220};
    tbl[14] = '{1'b1, 1'b0, 16'h0000, 4, 1'b0, 0, 5'b00000, 1'b0, 16'h0000};
    tbl[15] = '{1'b0, 1'b1, 16'h0300, 0, 1'b1, 0, 5'b00001, 1'b0, 16'h0300};
    tbl[16] = '{1'b0, 1'b1, 16'h0301, 0, 1'b1, 1, 5'b00001, 1'b0, 16'h0301};
    tbl[17] = '{1'b0, 1'b1, 16'h0302, 0, 1'b1, 2, 5'b00001, 1'b0, 16'h0302};
    tbl[18] = '{1'b0, 1'b1, 16'h0303, 0, 1'b1, 3, 5'b00001, 1'b0, 16'h0303};
    tbl[19] = '{1'b0, 1'b1, 16'h0310, 0, 1'b1, 0, 5'b00011, 1'b0, 16'h0310};
    tbl[20] = '{1'b0, 1'b1, 16'h0311, 2, 1'b1, 1, 5'b00011, 1'b0, 16'h0311};
    tbl[21] = '{1'b0, 1'b1, 16'h0312, 2, 1'b1, 2, 5'b00011, 1'b0, 16'h0312};

    reset = 1'b1; sof = 1'b0; in_valid = 1'b0; data_in = '0; line_len = '0;
    do_reset(1'b0);

    run_ramp(1'b0);
    run_ramp(1'b1);

    // Preamble for the table: 8-pixel lines up to line 2, col 4.
    for (int p = 0; p < 21; p++) cyc(p == 0, 1'b1, 16'((p/8)*16 + p%8), 8);
    for (int i = 0; i < NT; i++) begin
      cyc(tbl[i].sof, tbl[i].vld, tbl[i].din, tbl[i].len);
      chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_tv", i), tap_vld, tbl[i].e_tv);
      chk($sformatf("tbl%0d_err", i), cfg_err, tbl[i].e_err);
      chk($sformatf("tbl%0d_tap0", i), taps[15:0], tbl[i].e_tap0);
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_col", i), col, tbl[i].e_col);
    end

    // Oversized line_len clamps to MAX_LINE.
    cyc(1'b1, 1'b1, 16'h5000, 2000);
    for (int k = 1; k < 1024; k++) cyc(1'b0, 1'b1, 16'(16'h5000 + k), 0);
    chk("big_last_col", col, 10'd1023);
    chk("big_err", cfg_err, 1'b1);
    cyc(1'b0, 1'b1, 16'h6000, 0);
    chk("big_wrap_col", col, 10'd0);
    chk("big_wrap_tv", tap_vld, 5'b00011);

    // Reset while streaming at line 3, col 2.
    for (int p = 0; p < 26; p++) cyc(p == 0, 1'b1, 16'((p/8)*16 + p%8), 8);
    do_reset(1'b1);
    cyc(1'b0, 1'b1, 16'h00a0, 0);
    chk("postrst_col", col, 10'd0);
    chk("postrst_tv", tap_vld, 5'b00001);
    for (int k = 1; k < 10; k++) cyc(1'b0, 1'b1, 16'(16'h00a0 + k), 0);

    // Boundary line lengths, scoreboard-checked on every output.
    cyc(1'b1, 1'b1, 16'h0003, ML);
    for (int i = 1; i < 6*ML; i++) cyc(1'b0, 1'b1, 16'(i*7 + 3), 0);
    cyc(1'b1, 1'b1, 16'hbeef, 2);
    for (int i = 1; i < 12; i++) cyc(1'b0, 1'b1, 16'(i*13 + 16'h0100), 0);
    chk("len2_tv", tap_vld, 5'b11111);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
